// File: rtl/spi_types_pkg.sv
// Shared SPI types: transaction modes for spi_controller and arbiter FSM states.
// Imported by every block that talks to the shared controller.
package spi_types;

    typedef enum logic [2:0] {
        WRITE_8  = 3'd0,
        WRITE_16 = 3'd1,
        WRITE_24 = 3'd2,
        READ_8   = 3'd3,
        READ_16  = 3'd4,
        READ_24  = 3'd5
    } spi_transaction_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWNED = 2'd1,
        S_BUSY  = 2'd2
    } spi_arb_state_t;

    localparam int unsigned SPI_TX_W = 16;
    localparam int unsigned SPI_RX_W = 24;

    // One-hot encoding of a 2-port index: 0 -> 01, 1 -> 10.
    function automatic logic [1:0] port_onehot(input logic idx);
        return {idx, ~idx};
    endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker; on a tie the port that was not
// granted last wins. Shared with the VRAM port sharing logic.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one spi_controller between the display (port 0) and a secondary
// client (port 1): round-robin grant, locked bursts capped at MAX_HOLD.
//
// state   | meaning
// S_IDLE  | no owner, arbitrate among valid requesters
// S_OWNED | owner drives the controller and may issue
// S_BUSY  | accepted transaction in flight, waiting for i_ready
module spi_bus_arbiter
    import spi_types::*;
#(
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  spi_transaction_t      r0_mode,
    input  logic [SPI_TX_W-1:0]   r0_data,
    input  logic                  r0_dc,
    input  logic                  r0_lock,
    output logic                  r0_o_valid,
    output logic [SPI_RX_W-1:0]   r0_o_data,
    input  logic                  r0_o_ready,

    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  spi_transaction_t      r1_mode,
    input  logic [SPI_TX_W-1:0]   r1_data,
    input  logic                  r1_dc,
    input  logic                  r1_lock,
    output logic                  r1_o_valid,
    output logic [SPI_RX_W-1:0]   r1_o_data,
    input  logic                  r1_o_ready,

    output spi_transaction_t      spi_mode,
    output logic                  i_valid,
    output logic [SPI_TX_W-1:0]   i_data,
    input  logic                  i_ready,
    input  logic                  o_valid,
    input  logic [SPI_RX_W-1:0]   o_data,
    output logic                  o_ready,

    output logic                  data_commandb,
    output logic [1:0]            grant
);

    localparam int unsigned        HOLD_W     = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LIMIT = HOLD_W'(MAX_HOLD);

    spi_arb_state_t     state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_grant_q, last_grant_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               rd_owner_q, rd_owner_d;
    logic               dc_q, dc_d;
    logic               first_busy_q, first_busy_d;

    logic [1:0]             pick;
    logic                   own_valid;
    logic                   own_lock;
    logic                   own_dc;
    logic [SPI_TX_W-1:0]    own_data;
    spi_transaction_t       own_mode;

    rr_pick2 u_pick (
        .req  ({r1_valid, r0_valid}),
        .last (last_grant_q),
        .gnt  (pick)
    );

    always_comb begin
        own_valid = owner_q ? r1_valid : r0_valid;
        own_lock  = owner_q ? r1_lock  : r0_lock;
        own_dc    = owner_q ? r1_dc    : r0_dc;
        own_data  = owner_q ? r1_data  : r0_data;
        own_mode  = owner_q ? r1_mode  : r0_mode;
    end

    assign i_data   = own_data;
    assign spi_mode = own_mode;
    assign grant    = (state_q == S_IDLE) ? 2'b00 : port_onehot(owner_q);

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        hold_d        = hold_q;
        rd_owner_d    = rd_owner_q;
        dc_d          = dc_q;
        first_busy_d  = 1'b0;
        i_valid       = 1'b0;
        r0_ready      = 1'b0;
        r1_ready      = 1'b0;
        data_commandb = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (pick != 2'b00) begin
                    owner_d = pick[1];
                    hold_d  = '0;
                    state_d = S_OWNED;
                end
            end

            S_OWNED: begin
                i_valid       = own_valid;
                data_commandb = own_dc;
                if (own_valid && i_ready) begin
                    r0_ready     = ~owner_q;
                    r1_ready     = owner_q;
                    dc_d         = own_dc;
                    rd_owner_d   = owner_q;
                    hold_d       = (hold_q == HOLD_LIMIT) ? hold_q : hold_q + 1'b1;
                    first_busy_d = 1'b1;
                    state_d      = S_BUSY;
                end else if (!own_valid && !own_lock) begin
                    last_grant_d = owner_q;
                    state_d      = S_IDLE;
                end
            end

            S_BUSY: begin
                data_commandb = dc_q;
                // i_ready is still the accept-cycle value on the first busy cycle
                if (!first_busy_q && i_ready) begin
                    if (own_lock && (hold_q < HOLD_LIMIT)) begin
                        state_d = S_OWNED;
                    end else begin
                        last_grant_d = owner_q;
                        state_d      = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            hold_q       <= '0;
            rd_owner_q   <= 1'b0;
            dc_q         <= 1'b1;
            first_busy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            hold_q       <= hold_d;
            rd_owner_q   <= rd_owner_d;
            dc_q         <= dc_d;
            first_busy_q <= first_busy_d;
        end
    end

    // Read data follows the port that issued the most recent accepted request.
    assign r0_o_valid = o_valid & ~rd_owner_q;
    assign r1_o_valid = o_valid &  rd_owner_q;
    assign r0_o_data  = o_data;
    assign r1_o_data  = o_data;
    assign o_ready    = rd_owner_q ? r1_o_ready : r0_o_ready;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: instance 0 uses MAX_HOLD=64, instance 1
// uses MAX_HOLD=2; requester queues and a simple controller model drive both.
module tb_spi_bus_arbiter;
    import spi_types::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic             r0_valid [2];
    logic             r0_ready [2];
    spi_transaction_t r0_mode  [2];
    logic [15:0]      r0_data  [2];
    logic             r0_dc    [2];
    logic             r0_lock  [2];
    logic             r0_o_valid [2];
    logic [23:0]      r0_o_data  [2];
    logic             r0_o_ready [2];
    logic             r1_valid [2];
    logic             r1_ready [2];
    spi_transaction_t r1_mode  [2];
    logic [15:0]      r1_data  [2];
    logic             r1_dc    [2];
    logic             r1_lock  [2];
    logic             r1_o_valid [2];
    logic [23:0]      r1_o_data  [2];
    logic             r1_o_ready [2];
    spi_transaction_t spi_mode [2];
    logic             i_valid  [2];
    logic [15:0]      i_data   [2];
    logic             i_ready  [2];
    logic             o_valid  [2];
    logic [23:0]      o_data   [2];
    logic             o_ready  [2];
    logic             data_commandb [2];
    logic [1:0]       grant    [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        spi_bus_arbiter #(.MAX_HOLD(g == 0 ? 64 : 2)) dut (
            .clk(clk), .rst(rst),
            .r0_valid(r0_valid[g]), .r0_ready(r0_ready[g]), .r0_mode(r0_mode[g]),
            .r0_data(r0_data[g]), .r0_dc(r0_dc[g]), .r0_lock(r0_lock[g]),
            .r0_o_valid(r0_o_valid[g]), .r0_o_data(r0_o_data[g]), .r0_o_ready(r0_o_ready[g]),
            .r1_valid(r1_valid[g]), .r1_ready(r1_ready[g]), .r1_mode(r1_mode[g]),
            .r1_data(r1_data[g]), .r1_dc(r1_dc[g]), .r1_lock(r1_lock[g]),
            .r1_o_valid(r1_o_valid[g]), .r1_o_data(r1_o_data[g]), .r1_o_ready(r1_o_ready[g]),
            .spi_mode(spi_mode[g]), .i_valid(i_valid[g]), .i_data(i_data[g]),
            .i_ready(i_ready[g]), .o_valid(o_valid[g]), .o_data(o_data[g]),
            .o_ready(o_ready[g]), .data_commandb(data_commandb[g]), .grant(grant[g])
        );
    end

    int checks = 0;
    int failures = 0;

    // requester queues [instance][port][slot]
    logic [15:0]      q_data [2][2][16];
    logic             q_dc   [2][2][16];
    logic             q_lock [2][2][16];
    spi_transaction_t q_mode [2][2][16];
    int               wr [2][2];
    int               rd [2][2];
    logic             cur_lock [2][2];
    // controller model
    int               ccnt [2];
    logic             cpend [2];
    logic             chold [2];
    // per-cycle samples and accept log
    logic             acc  [2][2];
    logic             cacc [2];
    int               log_port [2][32];
    logic [15:0]      log_data [2][32];
    int               log_cyc  [2][32];
    int               nlog [2];
    int               cyc = 0;

    task automatic push(input int k, input int p, input spi_transaction_t m,
                        input logic [15:0] d, input logic dc, input logic lk);
        q_mode[k][p][wr[k][p] % 16] = m;
        q_data[k][p][wr[k][p] % 16] = d;
        q_dc[k][p][wr[k][p] % 16]   = dc;
        q_lock[k][p][wr[k][p] % 16] = lk;
        wr[k][p]++;
    endtask

    task automatic drive_all();
        for (int k = 0; k < 2; k++) begin
            r0_valid[k] = (rd[k][0] < wr[k][0]);
            r0_data[k]  = q_data[k][0][rd[k][0] % 16];
            r0_dc[k]    = q_dc[k][0][rd[k][0] % 16];
            r0_mode[k]  = q_mode[k][0][rd[k][0] % 16];
            r0_lock[k]  = cur_lock[k][0];
            r1_valid[k] = (rd[k][1] < wr[k][1]);
            r1_data[k]  = q_data[k][1][rd[k][1] % 16];
            r1_dc[k]    = q_dc[k][1][rd[k][1] % 16];
            r1_mode[k]  = q_mode[k][1][rd[k][1] % 16];
            r1_lock[k]  = cur_lock[k][1];
            i_ready[k]  = !chold[k] && (ccnt[k] == 0);
        end
    endtask

    task automatic clear_model(input int k);
        for (int p = 0; p < 2; p++) begin
            wr[k][p] = 0;
            rd[k][p] = 0;
            cur_lock[k][p] = 1'b0;
            q_data[k][p][0] = 16'h0;
            q_dc[k][p][0] = 1'b1;
            q_lock[k][p][0] = 1'b0;
            q_mode[k][p][0] = WRITE_8;
        end
        nlog[k] = 0;
        chold[k] = 1'b0;
        o_valid[k] = 1'b0;
        o_data[k] = 24'h0;
        r0_o_ready[k] = 1'b0;
        r1_o_ready[k] = 1'b0;
    endtask

    // Negedge: record what the coming posedge will do and check accept payloads.
    task automatic to_neg();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            acc[k][0] = r0_ready[k];
            acc[k][1] = r1_ready[k];
            cacc[k]   = i_valid[k] && i_ready[k];
            checks++;
            if ((r0_ready[k] | r1_ready[k]) !== cacc[k]) begin
                failures++;
                $display("FAIL accept_handshake[%0d]: ready=%b%b handshake=%b", k,
                         r1_ready[k], r0_ready[k], cacc[k]);
            end
            for (int p = 0; p < 2; p++) begin
                if (acc[k][p]) begin
                    checks++;
                    if (i_data[k] !== q_data[k][p][rd[k][p] % 16] ||
                        data_commandb[k] !== q_dc[k][p][rd[k][p] % 16] ||
                        spi_mode[k] !== q_mode[k][p][rd[k][p] % 16]) begin
                        failures++;
                        $display("FAIL accept_payload[%0d] port %0d: data=%h dc=%b mode=%0d expected data=%h dc=%b mode=%0d",
                                 k, p, i_data[k], data_commandb[k], spi_mode[k],
                                 q_data[k][p][rd[k][p] % 16], q_dc[k][p][rd[k][p] % 16],
                                 q_mode[k][p][rd[k][p] % 16]);
                    end
                end
            end
        end
    endtask

    // Posedge+1: advance requester queues and controller model, then drive.
    task automatic to_next();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                ccnt[k] = 0;
                cpend[k] = 1'b0;
                cur_lock[k][0] = 1'b0;
                cur_lock[k][1] = 1'b0;
            end else begin
                if (ccnt[k] > 0) ccnt[k]--;
                if (cpend[k]) begin
                    ccnt[k] = 3;
                    cpend[k] = 1'b0;
                end
                if (cacc[k]) cpend[k] = 1'b1;
                for (int p = 0; p < 2; p++) begin
                    if (acc[k][p]) begin
                        if (nlog[k] < 32) begin
                            log_port[k][nlog[k]] = p;
                            log_data[k][nlog[k]] = q_data[k][p][rd[k][p] % 16];
                            log_cyc[k][nlog[k]]  = cyc;
                            nlog[k]++;
                        end
                        cur_lock[k][p] = q_lock[k][p][rd[k][p] % 16];
                        rd[k][p]++;
                    end
                end
            end
        end
        drive_all();
    endtask

    task automatic run(input int budget);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            to_neg();
            done = (rd[0][0] == wr[0][0]) && (rd[0][1] == wr[0][1]) &&
                   (rd[1][0] == wr[1][0]) && (rd[1][1] == wr[1][1]) &&
                   (grant[0] == 2'b00) && (grant[1] == 2'b00);
            to_next();
            n++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL run_timeout: no idle after %0d cycles (grant0=%b grant1=%b)",
                     budget, grant[0], grant[1]);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        clear_model(0);
        clear_model(1);
        drive_all();
        for (int i = 0; i < 3; i++) begin
            to_neg();
            to_next();
        end
        rst = 1'b0;
        drive_all();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_model(0);
        clear_model(1);
        ccnt[0] = 0; ccnt[1] = 0; cpend[0] = 1'b0; cpend[1] = 1'b0;
        drive_all();
        for (int i = 0; i < 3; i++) begin
            to_neg();
            to_next();
        end
        rst = 1'b0;
        drive_all();
        to_neg();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (grant[k] !== 2'b00) begin
                failures++;
                $display("FAIL reset_grant[%0d]: got %b expected 00", k, grant[k]);
            end
            checks++;
            if (i_valid[k] !== 1'b0 || r0_ready[k] !== 1'b0 || r1_ready[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_handshake[%0d]: i_valid=%b ready=%b%b expected 0",
                         k, i_valid[k], r1_ready[k], r0_ready[k]);
            end
            checks++;
            if (data_commandb[k] !== 1'b1) begin
                failures++;
                $display("FAIL reset_dcb[%0d]: got %b expected 1", k, data_commandb[k]);
            end
            checks++;
            if (r0_o_valid[k] !== 1'b0 || r1_o_valid[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_o_valid[%0d]: got %b%b expected 00", k,
                         r1_o_valid[k], r0_o_valid[k]);
            end
        end
        to_next();
    endtask

    task automatic test_single_command();
        int n0;
        n0 = nlog[0];
        push(0, 0, WRITE_8, 16'h002C, 1'b0, 1'b0);
        drive_all();
        to_neg();
        checks++;
        if (grant[0] !== 2'b00 || i_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL single_arb_cycle: grant=%b i_valid=%b expected 00/0", grant[0], i_valid[0]);
        end
        to_next();
        to_neg();
        checks++;
        if (grant[0] !== 2'b01) begin
            failures++;
            $display("FAIL single_grant: got %b expected 01", grant[0]);
        end
        checks++;
        if (i_valid[0] !== 1'b1 || i_data[0] !== 16'h002C || spi_mode[0] !== WRITE_8) begin
            failures++;
            $display("FAIL single_issue: i_valid=%b i_data=%h mode=%0d expected 1/002c/0",
                     i_valid[0], i_data[0], spi_mode[0]);
        end
        checks++;
        if (data_commandb[0] !== 1'b0 || r0_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL single_accept: dcb=%b r0_ready=%b expected 0/1", data_commandb[0], r0_ready[0]);
        end
        to_next();
        for (int i = 0; i < 5; i++) begin
            to_neg();
            checks++;
            if (data_commandb[0] !== 1'b0 || i_valid[0] !== 1'b0 || grant[0] !== 2'b01) begin
                failures++;
                $display("FAIL single_busy cycle %0d: dcb=%b i_valid=%b grant=%b expected 0/0/01",
                         i, data_commandb[0], i_valid[0], grant[0]);
            end
            to_next();
        end
        to_neg();
        checks++;
        if (grant[0] !== 2'b00) begin
            failures++;
            $display("FAIL single_release: grant=%b expected 00", grant[0]);
        end
        checks++;
        if (nlog[0] !== n0 + 1) begin
            failures++;
            $display("FAIL single_count: accepts=%0d expected %0d", nlog[0] - n0, 1);
        end
        to_next();
    endtask

    task automatic test_tie();
        int          exp_p [4];
        logic [15:0] exp_d [4];
        exp_p = '{0, 1, 0, 1};
        exp_d = '{16'h0A00, 16'h0B00, 16'h0A01, 16'h0B01};
        reset_dut();
        push(0, 0, WRITE_8, 16'h0A00, 1'b1, 1'b0);
        push(0, 0, WRITE_8, 16'h0A01, 1'b1, 1'b0);
        push(0, 1, WRITE_8, 16'h0B00, 1'b1, 1'b0);
        push(0, 1, WRITE_8, 16'h0B01, 1'b1, 1'b0);
        drive_all();
        run(100);
        checks++;
        if (nlog[0] !== 4) begin
            failures++;
            $display("FAIL tie_count: accepts=%0d expected 4", nlog[0]);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (log_port[0][j] !== exp_p[j] || log_data[0][j] !== exp_d[j]) begin
                failures++;
                $display("FAIL tie_order[%0d]: port=%0d data=%h expected port=%0d data=%h",
                         j, log_port[0][j], log_data[0][j], exp_p[j], exp_d[j]);
            end
        end
    endtask

    task automatic test_lock_release();
        int          exp64 [5];
        int          exp2  [5];
        logic [15:0] expd2 [5];
        exp64 = '{1, 1, 1, 1, 0};
        exp2  = '{1, 1, 0, 1, 1};
        expd2 = '{16'hF800, 16'hF800, 16'h0001, 16'hF800, 16'hF800};
        reset_dut();
        for (int k = 0; k < 2; k++) begin
            push(k, 1, WRITE_16, 16'hF800, 1'b1, 1'b1);
            push(k, 1, WRITE_16, 16'hF800, 1'b1, 1'b1);
            push(k, 1, WRITE_16, 16'hF800, 1'b1, 1'b1);
            push(k, 1, WRITE_16, 16'hF800, 1'b1, 1'b0);
        end
        drive_all();
        to_neg();
        to_next();
        push(0, 0, WRITE_8, 16'h0001, 1'b1, 1'b0);
        push(1, 0, WRITE_8, 16'h0001, 1'b1, 1'b0);
        drive_all();
        run(200);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (nlog[k] !== 5) begin
                failures++;
                $display("FAIL lock_count[%0d]: accepts=%0d expected 5", k, nlog[k]);
            end
        end
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (log_port[0][j] !== exp64[j]) begin
                failures++;
                $display("FAIL lock_hold64_order[%0d]: port=%0d expected %0d", j, log_port[0][j], exp64[j]);
            end
            checks++;
            if (log_port[1][j] !== exp2[j] || log_data[1][j] !== expd2[j]) begin
                failures++;
                $display("FAIL lock_hold2_order[%0d]: port=%0d data=%h expected port=%0d data=%h",
                         j, log_port[1][j], log_data[1][j], exp2[j], expd2[j]);
            end
        end
        // locked accepts resume on the S_OWNED cycle right after the busy window
        for (int j = 1; j < 4; j++) begin
            checks++;
            if (log_cyc[0][j] - log_cyc[0][j-1] !== 6) begin
                failures++;
                $display("FAIL lock_back_to_back[%0d]: spacing=%0d expected 6", j,
                         log_cyc[0][j] - log_cyc[0][j-1]);
            end
        end
    endtask

    task automatic test_read_routing();
        int n0;
        int n;
        bit seen;
        n0 = nlog[0];
        push(0, 1, READ_24, 16'h0000, 1'b1, 1'b0);
        drive_all();
        n = 0;
        while (nlog[0] == n0 && n < 10) begin
            to_neg();
            to_next();
            n++;
        end
        checks++;
        if (nlog[0] == n0) begin
            failures++;
            $display("FAIL read_accept: r1 read accepted=0 expected 1");
        end
        push(0, 0, WRITE_8, 16'h0077, 1'b1, 1'b0);
        drive_all();
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            to_neg();
            if (grant[0] == 2'b00) seen = 1'b1;
            to_next();
            n++;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL read_release: grant never returned to 00 (now %b)", grant[0]);
        end
        chold[0] = 1'b1;
        o_valid[0] = 1'b1;
        o_data[0] = 24'h123456;
        r1_o_ready[0] = 1'b1;
        r0_o_ready[0] = 1'b0;
        drive_all();
        to_neg();
        checks++;
        if (grant[0] !== 2'b01 || r0_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL read_r0_holds: grant=%b r0_ready=%b expected 01/0", grant[0], r0_ready[0]);
        end
        checks++;
        if (r1_o_valid[0] !== 1'b1 || r0_o_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL read_route_r1: o_valid r1=%b r0=%b expected 1/0", r1_o_valid[0], r0_o_valid[0]);
        end
        checks++;
        if (r1_o_data[0] !== 24'h123456 || r0_o_data[0] !== 24'h123456) begin
            failures++;
            $display("FAIL read_fanout: r1=%h r0=%h expected 123456", r1_o_data[0], r0_o_data[0]);
        end
        checks++;
        if (o_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL read_o_ready_hi: got %b expected 1", o_ready[0]);
        end
        to_next();
        r1_o_ready[0] = 1'b0;
        r0_o_ready[0] = 1'b1;
        to_neg();
        checks++;
        if (o_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL read_o_ready_lo: got %b expected 0", o_ready[0]);
        end
        to_next();
        o_valid[0] = 1'b0;
        chold[0] = 1'b0;
        drive_all();
        run(50);
        o_valid[0] = 1'b1;
        o_data[0] = 24'hABCDEF;
        r0_o_ready[0] = 1'b1;
        r1_o_ready[0] = 1'b0;
        to_neg();
        checks++;
        if (r0_o_valid[0] !== 1'b1 || r1_o_valid[0] !== 1'b0 || o_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL read_route_r0: o_valid r0=%b r1=%b o_ready=%b expected 1/0/1",
                     r0_o_valid[0], r1_o_valid[0], o_ready[0]);
        end
        to_next();
        o_valid[0] = 1'b0;
        r0_o_ready[0] = 1'b0;
        drive_all();
    endtask

    task automatic test_reset_mid_burst();
        push(0, 0, WRITE_8, 16'h0055, 1'b1, 1'b0);
        drive_all();
        run(50);
        push(0, 0, WRITE_16, 16'hAA00, 1'b1, 1'b1);
        push(0, 0, WRITE_16, 16'hAA01, 1'b1, 1'b1);
        push(0, 0, WRITE_16, 16'hAA02, 1'b1, 1'b0);
        drive_all();
        to_neg();
        to_next();
        to_neg();
        checks++;
        if (r0_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL burst_accept: r0_ready=%b expected 1", r0_ready[0]);
        end
        to_next();
        to_neg();
        to_next();
        rst = 1'b1;
        drive_all();
        to_neg();
        checks++;
        if (grant[0] !== 2'b01 || data_commandb[0] !== 1'b1) begin
            failures++;
            $display("FAIL burst_busy: grant=%b dcb=%b expected 01/1", grant[0], data_commandb[0]);
        end
        to_next();
        rst = 1'b0;
        clear_model(0);
        drive_all();
        to_neg();
        checks++;
        if (grant[0] !== 2'b00 || i_valid[0] !== 1'b0 || data_commandb[0] !== 1'b1 ||
            r0_ready[0] !== 1'b0 || r0_o_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL burst_reset: grant=%b i_valid=%b dcb=%b r0_ready=%b r0_o_valid=%b expected 00/0/1/0/0",
                     grant[0], i_valid[0], data_commandb[0], r0_ready[0], r0_o_valid[0]);
        end
        to_next();
        push(0, 0, WRITE_8, 16'h0C00, 1'b1, 1'b0);
        push(0, 1, WRITE_8, 16'h0D00, 1'b1, 1'b0);
        drive_all();
        run(50);
        checks++;
        if (nlog[0] !== 2 || log_port[0][0] !== 0 || log_port[0][1] !== 1) begin
            failures++;
            $display("FAIL burst_tie_after_reset: accepts=%0d first=%0d second=%0d expected 2/0/1",
                     nlog[0], log_port[0][0], log_port[0][1]);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ccnt[0] = 0; ccnt[1] = 0;
        cpend[0] = 1'b0; cpend[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            acc[k][0] = 1'b0; acc[k][1] = 1'b0; cacc[k] = 1'b0;
        end
        test_reset();
        test_single_command();
        test_tie();
        test_lock_release();
        test_read_routing();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Shares the single `spi_controller` between two requesters: port 0 is the ILI9341 display controller, port 1 is a secondary client such as register readback or a debug/config master. The block arbitrates round-robin with a 1-cycle arbitration latency. It supports locked bursts so a command and its data bytes, or a pixel stream, stay atomic, and a `MAX_HOLD` limit forces release. It muxes `data_commandb` and routes read data back to the owner of the transaction.

## Interface
- `MAX_HOLD`, 64: maximum consecutive transactions one locked owner may issue before forced release.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rN_valid` in 1 (N=0,1): requester N has a transaction.
- `rN_ready` out 1: transaction accepted this cycle.
- `rN_mode` in `spi_transaction_t`: SPI mode of the request.
- `rN_data` in 16: transmit data.
- `rN_dc` in 1: data/command_bar for this transaction.
- `rN_lock` in 1: keep the grant after the current transaction.
- `rN_o_valid` out 1: read data valid, routed to the requester.
- `rN_o_data` out 24: read data, routed to the requester.
- `rN_o_ready` in 1: requester read ready.
- `spi_mode` out `spi_transaction_t`: to `spi_controller`.
- `i_valid` out 1: to `spi_controller`.
- `i_data` out 16: to `spi_controller`.
- `i_ready` in 1: from `spi_controller`.
- `o_valid` in 1: from `spi_controller`.
- `o_data` in 24: from `spi_controller`.
- `o_ready` out 1: to `spi_controller`.
- `data_commandb` out 1: to the display D/C pin.
- `grant` out 2: one-hot owner, `00` when idle.

## Operation
- States:
  - `S_IDLE`: no owner.
  - `S_OWNED`: owner may issue.
  - `S_BUSY`: transaction in flight.
- `S_IDLE`:
  - `i_valid`=0.
  - If exactly one `rN_valid` is high, grant it.
  - If both are high, grant the requester ≠ `last_grant`.
  - Go to `S_OWNED` next cycle with `hold_count`=0.
- `S_OWNED`:
  - `i_valid`, `i_data` and `spi_mode` mux from the owner.
  - `data_commandb` = owner `rN_dc`.
  - `rN_ready` = owner & `rN_valid` & `i_ready`.
  - On accept:
    - latch `dc_q`=`rN_dc`.
    - latch `rd_owner`=owner.
    - `hold_count`++.
    - go to `S_BUSY`.
  - If owner `valid`=0 and `lock`=0: go to `S_IDLE`, set `last_grant`=owner.
  - If owner `valid`=0 and `lock`=1: stay.
- `S_BUSY`:
  - `i_valid`=0; `data_commandb`=`dc_q`.
  - Ignore `i_ready` on the first `S_BUSY` cycle, because the controller deasserts `i_ready` the cycle after accept.
  - Exit on the first later cycle with `i_ready`=1:
    - If owner `lock`=1 and `hold_count` < `MAX_HOLD`: go to `S_OWNED`.
    - Otherwise: go to `S_IDLE`, set `last_grant`=owner.
- Forced release at `hold_count`==`MAX_HOLD` applies even if `lock` is still high. The owner re-competes in `S_IDLE` and loses any tie.
- Read routing:
  - `rN_o_valid` = `o_valid` & (`rd_owner`==N).
  - `o_ready` = `r[rd_owner]_o_ready`.
  - `o_data` fans out to both ports.
  - `rd_owner` persists until the next accept, so late `o_valid` still routes correctly.
- A requester dropping `valid` mid-`S_BUSY` has no effect; the in-flight transaction completes.
- `hold_count` width is `$clog2(MAX_HOLD+1)` and saturates at `MAX_HOLD`.

## Timing
- Reset values:
  - `state`=`S_IDLE`, `grant`=00.
  - `last_grant`=1, so r0 wins the first tie.
  - `hold_count`=0, `rd_owner`=0, `dc_q`=1.
  - `i_valid`=0, `rN_ready`=0, `rN_o_valid`=0.
  - `data_commandb`=1.
- Request-to-accept latency: 2 cycles minimum (`S_IDLE` grant, then `S_OWNED` accept when `i_ready`=1).
- Locked back-to-back: the next accept is possible on the cycle `S_BUSY` returns to `S_OWNED`. There is no re-arbitration gap.
- `data_commandb` is stable from the accept cycle through the end of `S_BUSY`.
- `rst` mid-`S_BUSY`: `S_IDLE` next cycle with all outputs at reset values. `spi_controller` shares `rst`, so no transaction is orphaned.
- Outputs `i_*`, `rN_ready` and `data_commandb` are combinational from the registered state/owner plus requester inputs; there are no comb paths from `i_ready` to `i_valid`.

## Structure
- Add `spi_arb_state_t` (`S_IDLE`, `S_OWNED`, `S_BUSY`) to the shared `spi_types` package next to `spi_transaction_t`.
- Sub-module `rr_pick2`: combinational 2-way round-robin picker with inputs `req[1:0]` and `last`, output one-hot `gnt`. It is reused by future VRAM port sharing.
- The top-level holds the FSM, `hold_count`, the latches and the muxes.

## Test plan
- Reset: hold `rst` 3 cycles → `grant`=00, `i_valid`=0, `data_commandb`=1, both `rN_o_valid`=0.
- Single command: r0 `WRITE_8`, data 0x002C, `dc`=0, `lock`=0 → `grant`=01 at cycle +1, `i_data`=0x002C with `i_valid` at +1, `data_commandb`=0 held through `S_BUSY`, then `S_IDLE` with `grant`=00.
- Tie: r0 and r1 valid from the first post-reset cycle, unlocked → accepts alternate r0, r1, r0, r1.
- Lock and forced release (`MAX_HOLD`=2):
  - Setup: r1 locked `WRITE_16` stream of 0xF800 ×4, with r0 valid throughout.
  - Expect: 2 r1 accepts, then r0 served, then r1 resumes.
  - Repeat with `MAX_HOLD`=64: all 4 r1 accepts occur before r0.
- Read routing: r1 read transaction, controller returns `o_data`=0x123456 while r0 holds a later grant → `r1_o_valid`=1, `r0_o_valid`=0, `o_ready` follows `r1_o_ready`.
- Reset mid-burst: assert `rst` in the second `S_BUSY` cycle of a locked r0 burst → next cycle `S_IDLE`, `grant`=00; a subsequent tie goes to r0.
